// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side control FSM for an oversampling UART. It tracks frame timing
// with a per-bit edge counter, majority-votes three mid-bit samples, strobes
// each data bit out to an external deserializer, checks optional parity and
// the stop bit, and reports one outcome pulse per completed frame.
//
// Parameters
//   DATA_WIDTH  data bits per frame, LSB first
//   PRESCALE    clocks per bit (even, >= 4)
//
// Ports
//   i_clk                  clock, all state changes on the rising edge
//   i_rst                  asynchronous active-high reset
//   i_rx_in                serial line (idle high), already synchronous
//   i_parity_enable        1 = a parity bit follows the data bits
//   i_parity_type          0 = even, 1 = odd
//   o_sampled_bit          majority-voted data bit for the deserializer
//   o_deserializer_enable  one-cycle shift strobe
//   o_data_valid           one-cycle pulse, frame received without error
//   o_parity_error         one-cycle pulse, parity mismatch
//   o_stop_error           one-cycle pulse, stop bit sampled low
//   o_busy                 high while a frame is being received
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx_in,
    input  logic i_parity_enable,
    input  logic i_parity_type,
    output logic o_sampled_bit,
    output logic o_deserializer_enable,
    output logic o_data_valid,
    output logic o_parity_error,
    output logic o_stop_error,
    output logic o_busy
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_S0   = CNT_W'(PRESCALE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_S1   = CNT_W'(PRESCALE / 2);
    localparam logic [CNT_W-1:0] CNT_S2   = CNT_W'(PRESCALE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter should have sent for the accumulated data XOR.
    function automatic logic parity_expected(input logic xor_acc, input logic odd);
        return xor_acc ^ odd;
    endfunction

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [IDX_W-1:0]  bit_idx_r;
    logic              samp0_r;
    logic              samp1_r;
    logic              samp2_r;
    logic              par_en_r;
    logic              par_type_r;
    logic              par_acc_r;
    logic              par_err_r;
    logic              armed_r;   // line seen high since reset; blocks mid-frame restarts

    logic              third_s;
    logic              vote_s;
    logic              bit_end_s;

    // Bit vote; with PRESCALE=4 the third sample edge is the bit end itself,
    // so the live line value is used instead of a stored sample.
    always_comb begin
        third_s   = (CNT_S2 == CNT_LAST) ? i_rx_in : samp2_r;
        vote_s    = maj3(samp0_r, samp1_r, third_s);
        bit_end_s = (cnt_r == CNT_LAST);
    end

    // Frame FSM, edge counter, sample capture and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r               <= ST_IDLE;
            cnt_r                 <= '0;
            bit_idx_r             <= '0;
            samp0_r               <= 1'b0;
            samp1_r               <= 1'b0;
            samp2_r               <= 1'b0;
            par_en_r              <= 1'b0;
            par_type_r            <= 1'b0;
            par_acc_r             <= 1'b0;
            par_err_r             <= 1'b0;
            armed_r               <= 1'b0;
            o_sampled_bit         <= 1'b0;
            o_deserializer_enable <= 1'b0;
            o_data_valid          <= 1'b0;
            o_parity_error        <= 1'b0;
            o_stop_error          <= 1'b0;
            o_busy                <= 1'b0;
        end else begin
            o_deserializer_enable <= 1'b0;
            o_data_valid          <= 1'b0;
            o_parity_error        <= 1'b0;
            o_stop_error          <= 1'b0;

            if (state_r != ST_IDLE) begin
                if (cnt_r == CNT_S0) samp0_r <= i_rx_in;
                if (cnt_r == CNT_S1) samp1_r <= i_rx_in;
                if (cnt_r == CNT_S2) samp2_r <= i_rx_in;
                if (bit_end_s) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (!armed_r) begin
                        armed_r <= i_rx_in;
                        cnt_r   <= '0;
                    end else if (!i_rx_in) begin
                        // This cycle is edge 0 of the start bit.
                        state_r    <= ST_START;
                        cnt_r      <= CNT_W'(1);
                        bit_idx_r  <= '0;
                        par_en_r   <= i_parity_enable;
                        par_type_r <= i_parity_type;
                        par_acc_r  <= 1'b0;
                        par_err_r  <= 1'b0;
                        o_busy     <= 1'b1;
                    end else begin
                        cnt_r <= '0;
                    end
                end

                ST_START: begin
                    if (bit_end_s) begin
                        if (vote_s) begin
                            state_r <= ST_IDLE;   // glitch, not a real start bit
                            o_busy  <= 1'b0;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end
                end

                ST_DATA: begin
                    if (bit_end_s) begin
                        o_sampled_bit         <= vote_s;
                        o_deserializer_enable <= 1'b1;
                        par_acc_r             <= par_acc_r ^ vote_s;
                        bit_idx_r             <= bit_idx_r + IDX_W'(1);
                        if (bit_idx_r == IDX_LAST) begin
                            state_r <= par_en_r ? ST_PARITY : ST_STOP;
                        end
                    end
                end

                ST_PARITY: begin
                    if (bit_end_s) begin
                        par_err_r <= (vote_s != parity_expected(par_acc_r, par_type_r));
                        state_r   <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (bit_end_s) begin
                        state_r <= ST_IDLE;
                        o_busy  <= 1'b0;
                        if (par_err_r || !vote_s) begin
                            o_parity_error <= par_err_r;
                            o_stop_error   <= !vote_s;
                        end else begin
                            o_data_valid <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// The whole line waveform and the expected output of every cycle are laid out
// in arrays from frame-level timing rules (bit k strobe at t0+(k+2)*P, outcome
// at t0+(W+2+Pbit)*P, busy from t0+1 to te-1), then replayed cycle by cycle.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int W = 8;
    localparam int P = 8;
    localparam int N = 4096;

    logic clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_rx_in = 1'b1;
    logic i_parity_enable = 1'b0;
    logic i_parity_type = 1'b0;
    logic o_sampled_bit, o_deserializer_enable, o_data_valid;
    logic o_parity_error, o_stop_error, o_busy;

    int tests = 0;
    int fails = 0;

    // stimulus per cycle
    logic line_a [N];
    logic rst_a  [N];
    logic pen_a  [N];
    logic pty_a  [N];
    // expectation per cycle
    logic de_a   [N];
    logic bit_a  [N];
    logic dv_a   [N];
    logic pe_a   [N];
    logic se_a   [N];
    logic busy_a [N];
    logic sb_a   [N];

    uart_rx_ctrl #(.DATA_WIDTH(W), .PRESCALE(P)) dut (
        .i_clk                 (clk),
        .i_rst                 (i_rst),
        .i_rx_in               (i_rx_in),
        .i_parity_enable       (i_parity_enable),
        .i_parity_type         (i_parity_type),
        .o_sampled_bit         (o_sampled_bit),
        .o_deserializer_enable (o_deserializer_enable),
        .o_data_valid          (o_data_valid),
        .o_parity_error        (o_parity_error),
        .o_stop_error          (o_stop_error),
        .o_busy                (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int n, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, n, obs, exp);
        end
    endtask

    // Lay out one frame starting at t0; returns the frame end cycle te.
    task automatic add_frame(input int t0, input logic [W-1:0] data, input logic pen,
                             input logic pty, input logic pbit, input logic sbit,
                             output int te);
        int nb;
        logic perr;
        nb = W + 2 + (pen ? 1 : 0);
        te = t0 + nb * P;
        for (int c = 0; c < P; c++) line_a[t0 + c] = 1'b0;
        for (int k = 0; k < W; k++) begin
            for (int c = 0; c < P; c++) line_a[t0 + (k + 1) * P + c] = data[k];
            de_a[t0 + (k + 2) * P]  = 1'b1;
            bit_a[t0 + (k + 2) * P] = data[k];
        end
        if (pen) begin
            for (int c = 0; c < P; c++) line_a[t0 + (W + 1) * P + c] = pbit;
        end
        for (int c = 0; c < P; c++) line_a[te - P + c] = sbit;
        pen_a[t0] = pen;
        pty_a[t0] = pty;
        for (int n = t0 + 1; n < te; n++) busy_a[n] = 1'b1;
        perr = pen && (pbit != ((^data) ^ pty));
        pe_a[te] = perr;
        se_a[te] = !sbit;
        dv_a[te] = !perr && sbit;
    endtask

    // Short low pulse that the start-bit vote rejects; returns the cycle the FSM is idle again.
    task automatic add_glitch(input int t0, input int len, output int nxt);
        for (int c = 0; c < len; c++) line_a[t0 + c] = 1'b0;
        for (int n = t0 + 1; n < t0 + P; n++) busy_a[n] = 1'b1;
        nxt = t0 + P;
    endtask

    initial begin
        int pos, te, last, rs;
        logic [W-1:0] d;
        logic pen, pty, pb, sb, cur;

        for (int n = 0; n < N; n++) begin
            line_a[n] = 1'b1;
            rst_a[n]  = 1'b0;
            pen_a[n]  = 1'($urandom_range(0, 1));   // changes mid-frame test latching
            pty_a[n]  = 1'($urandom_range(0, 1));
            de_a[n] = 1'b0; bit_a[n] = 1'b0; dv_a[n] = 1'b0;
            pe_a[n] = 1'b0; se_a[n] = 1'b0; busy_a[n] = 1'b0;
        end
        for (int n = 0; n < 4; n++) rst_a[n] = 1'b1;

        // Directed frames
        pos = 10;
        add_frame(pos, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, te); pos = te + 3;   // no parity
        add_frame(pos, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, te); pos = te + 2;   // parity error
        add_frame(pos, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, te); pos = te + 2;   // parity ok
        add_glitch(pos, 2, te); pos = te + 4;                                // start abort
        add_frame(pos, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, te); pos = te;       // stop error, restart at te
        add_frame(pos, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, te); pos = te;       // back-to-back
        add_frame(pos, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, te); pos = te + 1;
        add_frame(pos, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, te); pos = te + 2;   // odd parity ok + stop error
        add_frame(pos, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b0, te); pos = te + 2;   // both errors

        // Random frames and glitches
        while (pos < 3300) begin
            if ($urandom_range(0, 5) == 0) begin
                add_glitch(pos, int'($urandom_range(1, P / 2 - 1)), te);
            end else begin
                d   = W'($urandom);
                pen = 1'($urandom_range(0, 1));
                pty = 1'($urandom_range(0, 1));
                pb  = ($urandom_range(0, 1) == 0) ? ((^d) ^ pty) : 1'($urandom_range(0, 1));
                sb  = ($urandom_range(0, 4) != 0);
                add_frame(pos, d, pen, pty, pb, sb, te);
            end
            pos = te + int'($urandom_range(0, 4));
        end

        // Reset during data bit 3, line held low across release, then high
        rs = pos + 2;
        d  = 8'h96;                               // bit 3 is 0
        add_frame(rs, d, 1'b0, 1'b0, 1'b0, 1'b1, te);
        for (int n = rs + 32; n < rs + 72; n++) line_a[n] = 1'b0;
        for (int n = rs + 72; n < rs + 102; n++) line_a[n] = 1'b1;
        rst_a[rs + 35] = 1'b1;
        rst_a[rs + 36] = 1'b1;
        for (int n = rs + 35; n < rs + 102; n++) begin
            de_a[n] = 1'b0; bit_a[n] = 1'b0; dv_a[n] = 1'b0;
            pe_a[n] = 1'b0; se_a[n] = 1'b0; busy_a[n] = 1'b0;
        end
        pos = rs + 102;
        add_frame(pos, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, te);   // recovery frame
        last = te + 10;

        // Sampled bit holds the last strobed value; reset clears it.
        cur = 1'b0;
        for (int n = 0; n < last; n++) begin
            if (rst_a[n]) cur = 1'b0;
            if (de_a[n])  cur = bit_a[n];
            sb_a[n] = cur;
        end

        // Replay: drive cycle n at the falling edge, check outputs shortly after.
        for (int n = 0; n < last; n++) begin
            @(negedge clk);
            i_rx_in         = line_a[n];
            i_rst           = rst_a[n];
            i_parity_enable = pen_a[n];
            i_parity_type   = pty_a[n];
            #1;
            check("strobe", n, o_deserializer_enable, de_a[n]);
            check("sampled_bit", n, o_sampled_bit, sb_a[n]);
            check("data_valid", n, o_data_valid, dv_a[n]);
            check("parity_error", n, o_parity_error, pe_a[n]);
            check("stop_error", n, o_stop_error, se_a[n]);
            check("busy", n, o_busy, busy_a[n]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
